// File: rtl/frame_reader_dma.sv
// Frame reader: streams one H_RES x V_RES frame of pixels from SDRAM via a pipelined
// Avalon-MM read master into a FIFO-backed valid/ready stream. Option: FRAME_READER_LOOP_EN.
module frame_reader_dma #(
  parameter int MASTER_ADDRESSWIDTH = 32,
  parameter int DATAWIDTH           = 32,
  parameter int H_RES               = 640,
  parameter int V_RES               = 480,
  parameter int FIFO_DEPTH          = 64,
  parameter int MAX_PENDING         = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MASTER_ADDRESSWIDTH-1:0] frame_base,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overflow_err,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic [DATAWIDTH-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sop,
  output logic                           out_eop
);
  // state   | meaning
  // S_IDLE  | waiting for start
  // S_READ  | issuing read requests for the frame
  // S_DRAIN | all requests issued, waiting for the last pixel to be popped
  localparam int TOTAL  = H_RES * V_RES;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
`ifdef FRAME_READER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [MASTER_ADDRESSWIDTH-1:0] base_q, addr_q;
  logic [CNT_W-1:0]  issue_cnt, pop_cnt;
  logic [PEND_W-1:0] pending;
  logic [DATAWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_count;
  logic start_acc, accept, last_accept, push_req, push, pop, last_pop;
  logic fifo_full, fifo_empty, issue_ok, issue_en;

  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign start_acc   = start && (state == S_IDLE);
  assign accept      = master_read && !master_waitrequest;
  assign last_accept = accept && (issue_cnt == LAST_IDX);
  assign pop         = !fifo_empty && out_ready;
  assign last_pop    = pop && (pop_cnt == LAST_IDX);
  // Returns with nothing outstanding are leftovers from before a reset and are dropped.
  assign push_req    = master_readdatavalid && (pending != '0);
  assign push        = push_req && (!fifo_full || pop);
  // Credit rule: every outstanding read has a guaranteed FIFO slot.
  assign issue_ok    = (32'(pending) < 32'(MAX_PENDING)) &&
                       (32'(fifo_count) + 32'(pending) < 32'(FIFO_DEPTH));
  assign issue_en    = (state == S_READ) || (LOOP && (state == S_DRAIN));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (last_accept) state_nxt = S_DRAIN;
      S_DRAIN: if (last_pop) state_nxt = LOOP ? S_READ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != S_IDLE);
    master_read    = issue_en && issue_ok;
    master_address = addr_q;
    out_valid      = !fifo_empty;
    out_data       = fifo_empty ? '0 : mem[rd_ptr];
    out_sop        = !fifo_empty && (pop_cnt == '0);
    out_eop        = !fifo_empty && (pop_cnt == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q       <= '0;
      addr_q       <= '0;
      issue_cnt    <= '0;
      pop_cnt      <= '0;
      pending      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      frame_done   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      frame_done <= last_pop;
      if (push_req && fifo_full && !pop) overflow_err <= 1'b1;
      if (start_acc) begin
        base_q    <= frame_base;
        addr_q    <= frame_base;
        issue_cnt <= '0;
        pop_cnt   <= '0;
      end else begin
        // Issue side wraps to the frame base so a looping reader restarts seamlessly.
        if (accept) begin
          issue_cnt <= last_accept ? '0 : issue_cnt + 1'b1;
          addr_q    <= last_accept ? base_q : addr_q + MASTER_ADDRESSWIDTH'(4);
        end
        if (pop) pop_cnt <= last_pop ? '0 : pop_cnt + 1'b1;
      end
      case ({accept, push_req})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= master_readdata;
  end
endmodule

// File: tb/tb_frame_reader_dma.sv
// Bench for frame_reader_dma: random Avalon slave plus a frame-level reference model
// (address k of a frame is base+4k, pixel k is the memory word at that address).
module tb_frame_reader_dma;
  localparam int AW = 32, DW = 32, H = 4, V = 2, TOTAL = H * V, FD = 4, MP = 8;
`ifdef FRAME_READER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, start;
  logic [AW-1:0] frame_base, master_address;
  logic busy, frame_done, overflow_err, master_read;
  logic [DW-1:0] master_readdata, out_data;
  logic master_readdatavalid, master_waitrequest, out_valid, out_ready, out_sop, out_eop;

  always #5 clk = ~clk;

  frame_reader_dma #(
    .MASTER_ADDRESSWIDTH(AW), .DATAWIDTH(DW), .H_RES(H), .V_RES(V),
    .FIFO_DEPTH(FD), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_base(frame_base),
    .busy(busy), .frame_done(frame_done), .overflow_err(overflow_err),
    .master_address(master_address), .master_read(master_read),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop)
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  logic [31:0] rsp_data[$];
  int rsp_due[$];
  int lat_min = 2, lat_max = 2, wait_pct = 0, ready_pct = 100;
  int stall_idx = 0, stall_left = 0, hold_cnt = 0;
  logic [31:0] m_base = '0;
  logic m_busy = 1'b0, exp_done = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  int acc_k = 0, pop_k = 0, n_frames = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3 ^ (a << 3);
  endfunction

  // One clock: drive inputs, settle, check against the model, advance.
  task automatic sim_cycle();
    int idx, tmp;
    logic lastp, start_ok;
    lastp = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata = '0;
    if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
      master_readdatavalid = 1'b1;
      master_readdata = rsp_data.pop_front();
      tmp = rsp_due.pop_front();
    end
    master_waitrequest = (stall_left > 0 && acc_k == stall_idx) || ($urandom_range(99) < wait_pct);
    out_ready = ($urandom_range(99) < ready_pct);
    #1;
    if (reset_n) begin
      chk("busy", busy, m_busy);
      chk("frame_done", frame_done, exp_done);
      chk("overflow_err", overflow_err, 0);
      if (!m_busy) chk("idle_out_valid", out_valid, 0);
      if (prev_stall) begin
        chk("read_held", master_read, 1);
        chk("addr_held", master_address, prev_addr);
      end
      if (master_read && acc_k == 1 && master_address == m_base + 4) hold_cnt++;
      if (master_read && master_waitrequest && stall_left > 0 && acc_k == stall_idx) stall_left--;
      if (master_read && !master_waitrequest) begin
        if (!LOOP && acc_k >= TOTAL) chk("read_beyond_frame", acc_k, TOTAL - 1);
        else chk("address", master_address, m_base + 4 * (acc_k % TOTAL));
        acc_k++;
        chk("credit", (acc_k - pop_k) <= FD, 1);
        rsp_data.push_back(mem_word(master_address));
        rsp_due.push_back(cyc + $urandom_range(lat_max, lat_min));
      end
      if (out_valid && out_ready) begin
        idx = pop_k % TOTAL;
        chk("pixel", out_data, mem_word(m_base + 4 * idx));
        chk("sop", out_sop, idx == 0);
        chk("eop", out_eop, idx == TOTAL - 1);
        pop_k++;
        lastp = (idx == TOTAL - 1);
      end
      start_ok = start && !m_busy;
      exp_done = lastp;
      if (lastp) n_frames++;
      if (lastp && !LOOP) m_busy = 1'b0;
      if (start_ok) begin
        m_busy = 1'b1;
        m_base = frame_base;
        acc_k = 0;
        pop_k = 0;
      end
      prev_stall = master_read && master_waitrequest;
      prev_addr = master_address;
    end else begin
      // The slave still honours a request accepted during reset; its data becomes stale.
      if (master_read && !master_waitrequest) begin
        rsp_data.push_back(mem_word(master_address));
        rsp_due.push_back(cyc + lat_max);
      end
      m_busy = 1'b0;
      exp_done = 1'b0;
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs();
    chk("rst_master_read", master_read, 0);
    chk("rst_master_address", master_address, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow_err", overflow_err, 0);
  endtask

  task automatic reset_and_drain();
    reset_n = 1'b0;
    sim_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 40 && rsp_due.size() > 0; i++) sim_cycle();
    chk("drain_timeout", rsp_due.size(), 0);
  endtask

  task automatic start_frame(logic [31:0] base);
    frame_base = base;
    start = 1'b1;
    sim_cycle();
    start = 1'b0;
  endtask

  task automatic run_until_frames(int target, int budget);
    for (int i = 0; i < budget && n_frames < target; i++) sim_cycle();
    chk("frame_timeout", n_frames, target);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; frame_base = '0;
    master_readdata = '0; master_readdatavalid = 1'b0;
    master_waitrequest = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    sim_cycle();
    sim_cycle();
    reset_n = 1'b1;
    check_reset_outputs();

    // Baseline: no stalls, latency 2, always ready (loop build runs two frames).
    start_frame(32'h0800_0000);
    run_until_frames(LOOP ? 2 : 1, 200);
    for (int i = 0; i < 4; i++) sim_cycle();
    chk("baseline_reads", acc_k, LOOP ? acc_k : TOTAL);

    // Slave stalls the second request for three cycles.
    reset_and_drain();
    stall_idx = 1; stall_left = 3; hold_cnt = 0;
    start_frame(32'h0800_0000);
    run_until_frames(n_frames + 1, 200);
    chk("stall_hold_cycles", hold_cnt, 4);
    chk("stall_consumed", stall_left, 0);

    // Downstream blocked: credit limits reads to the FIFO depth.
    reset_and_drain();
    ready_pct = 0;
    start_frame(32'h0800_0000);
    for (int i = 0; i < 30; i++) sim_cycle();
    chk("fifo_reads", acc_k, FD);
    chk("read_stalled", master_read, 0);
    chk("fifo_head_valid", out_valid, 1);
    ready_pct = 100;
    run_until_frames(n_frames + 1, 200);

    // Second start mid-frame is ignored.
    reset_and_drain();
    start_frame(32'h0800_0400);
    for (int i = 0; i < 4; i++) sim_cycle();
    start_frame(32'h0900_0000);
    run_until_frames(n_frames + 1, 200);
    chk("restart_ignored_base", m_base, 32'h0800_0400);

    // Reset with reads outstanding; stale returns must not reach the FIFO.
    reset_and_drain();
    lat_min = 6; lat_max = 6; ready_pct = 0;
    start_frame(32'h0800_0000);
    for (int i = 0; i < 10 && rsp_due.size() < 3; i++) sim_cycle();
    chk("pending_reached", rsp_due.size() >= 3, 1);
    reset_n = 1'b0;
    sim_cycle();
    reset_n = 1'b1;
    check_reset_outputs();
    for (int i = 0; i < 12; i++) sim_cycle();
    chk("stale_dropped", out_valid, 0);
    lat_min = 2; lat_max = 2; ready_pct = 100;
    start_frame(32'h0810_0000);
    run_until_frames(n_frames + 1, 200);
    chk("new_base", m_base, 32'h0810_0000);

    // Randomised frames: random stalls, latency, backpressure and base.
    wait_pct = 30; ready_pct = 60; lat_min = 1; lat_max = MP;
    for (int f = 0; f < 6; f++) begin
      reset_and_drain();
      start_frame(32'h0800_0000 + ($urandom_range(0, 4095) << 4));
      run_until_frames(n_frames + 1, 1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frame_reader_dma.md
Name: frame_reader_dma

Overview:
- Downstream consumer of the SDRAM pixel buffer that the PCIe-controlled master fills.
- On a start pulse, it reads one full frame of 32-bit pixels from SDRAM over a pipelined Avalon-MM read master.
- Read data is buffered in an internal FIFO and emitted as a valid/ready pixel stream with start/end-of-frame markers, for the VGA output stage.

Parameters:
MASTER_ADDRESSWIDTH, 32, Avalon master address width (byte addresses)
DATAWIDTH, 32, pixel/data width
H_RES, 640, pixels per line
V_RES, 480, lines per frame
FIFO_DEPTH, 64, pixel FIFO entries (power of 2)
MAX_PENDING, 8, maximum outstanding read requests

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begin frame read
frame_base  in  MASTER_ADDRESSWIDTH  byte address of pixel 0, sampled on accepted start
busy  out  1  high from accepted start until last pixel popped
frame_done  out  1  one-cycle pulse when the last pixel of a frame is popped
overflow_err  out  1  sticky; readdatavalid arrived with FIFO full
master_address  out  MASTER_ADDRESSWIDTH  read address
master_read  out  1  read request
master_readdata  in  DATAWIDTH  read data
master_readdatavalid  in  1  read data valid
master_waitrequest  in  1  slave stall
out_data  out  DATAWIDTH  pixel (FIFO head)
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_sop  out  1  qualifies out_data as pixel 0 of frame
out_eop  out  1  qualifies out_data as pixel H_RES*V_RES-1

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, counters 0, overflow_err cleared. Reset mid-frame aborts; data returning after reset is discarded.
- TOTAL = H_RES*V_RES. Addresses step by 4. Last address = frame_base + 4*(TOTAL-1); default frame 0x08000000 gives last 0x0812BFFC. No wrap within the frame.
- States:
  - IDLE: start -> latch frame_base, clear issue/pop counters, busy=1, go to READ.
  - READ: issue reads; after request TOTAL-1 is accepted, go to DRAIN.
  - DRAIN: wait for pixels; pop of pixel TOTAL-1 -> frame_done pulse, busy=0, go to IDLE.
- start while busy is ignored.
- Issue rule: master_read=1 in READ when pending < MAX_PENDING and fifo_count + pending < FIFO_DEPTH.
- Once asserted, master_read and master_address stay stable until a cycle with master_waitrequest=0 (accept). After accept, the address advances by 4 and the next request may assert on the following cycle.
- pending: +1 on accept, -1 on readdatavalid; both in the same cycle -> unchanged.
- readdatavalid writes master_readdata into the FIFO the same edge. If the FIFO is full, the data is dropped and overflow_err set; this is unreachable under the credit rule.
- FIFO: first-word-through. out_valid = !empty, out_data = head. Pop on out_valid && out_ready. Simultaneous push and pop at full or empty is legal; count is unchanged.
- out_sop high when the head is pixel index 0 of the current frame; out_eop high when the head is index TOTAL-1. Index counted by pops.
- Throughput: one pixel per cycle sustained when waitrequest=0, readdata latency <= MAX_PENDING, and out_ready=1.

Optional Feature:
- Macro: FRAME_READER_LOOP_EN.
- Defined:
  - After frame_done, the block restarts automatically from the same latched frame_base without a start pulse.
  - Issue of the next frame may begin in DRAIN once TOTAL requests have been issued; sop/eop indexing restarts per frame.
  - busy stays high; reset_n is the only way to stop.
- Undefined: single-shot behaviour as above.

Test Plan:
- H_RES=4, V_RES=2, frame_base=0x08000000, waitrequest=0, readdata latency 2, out_ready=1 -> addresses 0x08000000..0x0800001C each once; 8 pixels out in order; sop on pixel 0, eop on pixel 7; frame_done one cycle; busy falls the same cycle.
- Same frame, waitrequest high 3 cycles on the 2nd request -> master_address held at 0x08000004 and master_read held for all 4 cycles; no duplicate or skipped address.
- FIFO_DEPTH=4, out_ready=0 throughout -> exactly 4 reads accepted, then master_read=0; overflow_err stays 0. Raising out_ready resumes reads.
- start pulsed again mid-frame -> ignored: no address restart, single frame_done.
- reset_n low for 1 cycle with 3 reads pending -> all outputs 0 next cycle; late readdatavalid pulses do not fill the FIFO; a new start then reads from the new frame_base.
- FRAME_READER_LOOP_EN defined, 4x2 frame, out_ready=1 -> two consecutive frames, 16 pixels, sop at pixels 0 and 8, frame_done twice, second frame re-reading from 0x08000000.
